// File: rtl/wave_pkg.sv
// Shared types and defaults for the wave-request selector and its ack return path.
// Both directions import this so channel counts and state encoding stay in lockstep.
package wave_pkg;

  localparam int WAVE_N_CH    = 8;
  localparam int WAVE_SEL_W   = 8;
  localparam int WAVE_TIMEOUT = 1024;
  localparam int WAVE_ACK_LEN = 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    DRAIN
  } wave_state_t;

endpackage

// File: rtl/wave_timeout_cnt.sv
// Saturating cycle counter for the ack-wait window.
// term is high once the count reaches LIMIT-1 and stays there until clr.
module wave_timeout_cnt
  import wave_pkg::*;
#(
  parameter  int LIMIT = WAVE_TIMEOUT,
  localparam int W     = $clog2(LIMIT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic term
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign term = (cnt == LAST);

endmodule

// File: rtl/wave_ack_router.sv
// Routes the wave engine's ack back to the channel whose request was locked,
// with per-transaction channel lock, timeout abort and spurious-ack detection.
module wave_ack_router
  import wave_pkg::*;
#(
  parameter  int N_CH    = WAVE_N_CH,
  parameter  int TIMEOUT = WAVE_TIMEOUT,
  parameter  int ACK_LEN = WAVE_ACK_LEN,
  localparam int CH_W    = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WAVE_SEL_W-1:0] wave_sel,
  input  logic                  Wave_req,
  input  logic                  Wave_ack,
  input  logic                  err_clr,
  output logic [N_CH-1:0]       Logics_ack,
  output logic                  busy,
  output logic [CH_W-1:0]       active_ch,
  output logic                  timeout_err,
  output logic [CH_W-1:0]       timeout_ch,
  output logic                  spur_err
);

  localparam int AW = (ACK_LEN > 1) ? $clog2(ACK_LEN) : 1;
  localparam logic [AW-1:0] ACK_LAST = AW'(ACK_LEN - 1);
  localparam logic [WAVE_SEL_W-1:0] SEL_LIM = WAVE_SEL_W'(N_CH);
  localparam logic [N_CH-1:0] ONE = N_CH'(1);

  wave_state_t           state;
  logic [WAVE_SEL_W-1:0] sel_d;
  logic [AW-1:0]         ack_cnt;
  logic                  term;
  logic                  cnt_clr;
  logic                  cnt_en;

  assign cnt_clr = (state == IDLE);
  assign cnt_en  = (state == WAIT);

  wave_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .term (term)
  );

  // sel_d lines up with Wave_req, which the selector registers once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_d <= '0;
    else        sel_d <= wave_sel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      Logics_ack  <= '0;
      busy        <= 1'b0;
      active_ch   <= '0;
      timeout_err <= 1'b0;
      timeout_ch  <= '0;
      spur_err    <= 1'b0;
      ack_cnt     <= '0;
    end else begin
      if (err_clr) begin
        timeout_err <= 1'b0;
        spur_err    <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (Wave_ack) spur_err <= 1'b1;
          if (Wave_req && sel_d < SEL_LIM) begin
            active_ch <= sel_d[CH_W-1:0];
            busy      <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // ack beats a timeout landing on the same cycle
          if (Wave_ack) begin
            Logics_ack <= ONE << active_ch;
            ack_cnt    <= '0;
            state      <= ACK;
          end else if (term) begin
            timeout_err <= 1'b1;
            timeout_ch  <= active_ch;
            state       <= DRAIN;
          end
        end
        ACK: begin
          if (ack_cnt == ACK_LAST) begin
            Logics_ack <= '0;
            state      <= DRAIN;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (!Wave_req) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_ack_router.sv
// Directed bench for wave_ack_router: routing, channel lock, timeout,
// spurious ack, out-of-range select and reset during an ack pulse.
module tb_wave_ack_router;

  localparam int TO = 20;
  localparam int AL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] wave_sel;
  logic       Wave_req;
  logic       Wave_ack;
  logic       err_clr;
  logic [7:0] Logics_ack;
  logic       busy;
  logic [2:0] active_ch;
  logic       timeout_err;
  logic [2:0] timeout_ch;
  logic       spur_err;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  wave_ack_router #(
    .N_CH   (8),
    .TIMEOUT(TO),
    .ACK_LEN(AL)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wave_sel   (wave_sel),
    .Wave_req   (Wave_req),
    .Wave_ack   (Wave_ack),
    .err_clr    (err_clr),
    .Logics_ack (Logics_ack),
    .busy       (busy),
    .active_ch  (active_ch),
    .timeout_err(timeout_err),
    .timeout_ch (timeout_ch),
    .spur_err   (spur_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    wave_sel = '0;
    Wave_req = 1'b0;
    Wave_ack = 1'b0;
    err_clr  = 1'b0;
    #3;
    chk("rst_lack", 32'(Logics_ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ach", 32'(active_ch), 32'h0);
    chk("rst_terr", 32'(timeout_err), 32'h0);
    chk("rst_tch", 32'(timeout_ch), 32'h0);
    chk("rst_spur", 32'(spur_err), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // 1: basic route of ch 3
    wave_sel = 8'd3;
    tick(1);
    Wave_req = 1'b1;
    tick(1);
    chk("t1_busy", 32'(busy), 32'h1);
    chk("t1_ach", 32'(active_ch), 32'h3);
    chk("t1_noack", 32'(Logics_ack), 32'h0);
    tick(4);
    Wave_ack = 1'b1;
    tick(1);
    Wave_ack = 1'b0;
    chk("t1_ack0", 32'(Logics_ack), 32'h08);
    for (int i = 1; i < AL; i++) begin
      tick(1);
      chk("t1_ackn", 32'(Logics_ack), 32'h08);
    end
    tick(1);
    chk("t1_ackend", 32'(Logics_ack), 32'h0);
    chk("t1_drbusy", 32'(busy), 32'h1);
    Wave_req = 1'b0;
    tick(1);
    chk("t1_idle", 32'(busy), 32'h0);
    wave_sel = 8'd0;

    // 2: lock ch 2, sel moves to 6, ack held long
    wave_sel = 8'd2;
    tick(1);
    Wave_req = 1'b1;
    tick(1);
    chk("t2_ach0", 32'(active_ch), 32'h2);
    wave_sel = 8'd6;
    tick(2);
    chk("t2_ach1", 32'(active_ch), 32'h2);
    Wave_ack = 1'b1;
    tick(1);
    chk("t2_ack0", 32'(Logics_ack), 32'h04);
    tick(AL - 1);
    chk("t2_ackn", 32'(Logics_ack), 32'h04);
    tick(1);
    chk("t2_ackend", 32'(Logics_ack), 32'h0);
    tick(2);
    chk("t2_norecount", 32'(Logics_ack), 32'h0);
    chk("t2_nospur", 32'(spur_err), 32'h0);
    chk("t2_ach2", 32'(active_ch), 32'h2);
    Wave_ack = 1'b0;
    Wave_req = 1'b0;
    tick(1);
    chk("t2_idle", 32'(busy), 32'h0);
    wave_sel = 8'd0;

    // 3: timeout on ch 5
    wave_sel = 8'd5;
    tick(1);
    Wave_req = 1'b1;
    tick(1);
    tick(TO - 1);
    chk("t3_pre_terr", 32'(timeout_err), 32'h0);
    chk("t3_pre_busy", 32'(busy), 32'h1);
    tick(1);
    chk("t3_terr", 32'(timeout_err), 32'h1);
    chk("t3_tch", 32'(timeout_ch), 32'h5);
    chk("t3_noack", 32'(Logics_ack), 32'h0);
    chk("t3_drbusy", 32'(busy), 32'h1);
    Wave_req = 1'b0;
    tick(1);
    chk("t3_idle", 32'(busy), 32'h0);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t3_clr", 32'(timeout_err), 32'h0);
    chk("t3_tch_keep", 32'(timeout_ch), 32'h5);
    wave_sel = 8'd0;

    // 4: spurious ack, then ack on the terminal count
    Wave_ack = 1'b1;
    tick(1);
    Wave_ack = 1'b0;
    chk("t4_spur", 32'(spur_err), 32'h1);
    chk("t4_noack", 32'(Logics_ack), 32'h0);
    chk("t4_nobusy", 32'(busy), 32'h0);
    wave_sel = 8'd1;
    tick(1);
    Wave_req = 1'b1;
    tick(1);
    tick(TO - 1);
    chk("t4_pre_busy", 32'(busy), 32'h1);
    Wave_ack = 1'b1;
    tick(1);
    Wave_ack = 1'b0;
    chk("t4_lastack", 32'(Logics_ack), 32'h02);
    chk("t4_noterr", 32'(timeout_err), 32'h0);
    tick(AL);
    chk("t4_ackend", 32'(Logics_ack), 32'h0);
    chk("t4_noterr2", 32'(timeout_err), 32'h0);
    Wave_req = 1'b0;
    tick(1);
    wave_sel = 8'd0;
    err_clr  = 1'b1;
    Wave_ack = 1'b1;
    tick(1);
    err_clr  = 1'b0;
    Wave_ack = 1'b0;
    chk("t4_setwins", 32'(spur_err), 32'h1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    chk("t4_clr", 32'(spur_err), 32'h0);

    // 5: out-of-range select
    wave_sel = 8'h09;
    tick(1);
    Wave_req = 1'b1;
    tick(3);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_noack", 32'(Logics_ack), 32'h0);
    chk("t5_terr", 32'(timeout_err), 32'h0);
    chk("t5_spur", 32'(spur_err), 32'h0);
    Wave_req = 1'b0;
    wave_sel = 8'd0;
    tick(1);

    // 6: reset in the middle of an ack pulse on ch 7
    Wave_ack = 1'b1;
    tick(1);
    Wave_ack = 1'b0;
    wave_sel = 8'd7;
    tick(1);
    Wave_req = 1'b1;
    tick(1);
    Wave_ack = 1'b1;
    tick(1);
    Wave_ack = 1'b0;
    chk("t6_ack", 32'(Logics_ack), 32'h80);
    chk("t6_spur_pre", 32'(spur_err), 32'h1);
    tick(1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_cut", 32'(Logics_ack), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_spur", 32'(spur_err), 32'h0);
    chk("t6_ach", 32'(active_ch), 32'h0);
    Wave_req = 1'b0;
    wave_sel = 8'd0;
    tick(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk("t6_noack", 32'(Logics_ack), 32'h0);
    end
    chk("t6_idle", 32'(busy), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
